// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the interrupt controller.
package irq_ctrl_pkg;

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
    localparam logic [2:0] ADDR_SW_SET   = 3'd4;
    localparam logic [2:0] ADDR_RAW      = 3'd5;

    localparam int ID_W = 4;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [ID_W-1:0] lowest_set(input logic [15:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) id = ID_W'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Single-bit multi-stage synchroniser, resets to 0.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ff_q <= '0;
        else          ff_q <= {ff_q[STAGES-2:0], d_i};
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Avalon-MM interrupt controller: level/edge latching, mask, priority encode.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                chipselect,
    input  logic [2:0]          address,
    input  logic                write_n,
    input  logic [15:0]         writedata,
    output logic [15:0]         readdata,
    input  logic [NUM_SRC-1:0]  irq_in,
    output logic                irq_out,
    output logic [ID_W-1:0]     irq_id
);

    logic [NUM_SRC-1:0] s, s_d_q;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] edge_sel_q, edge_sel_d;
    logic [NUM_SRC-1:0] e_q, e_d;
    logic [NUM_SRC-1:0] pending, active, rise, w1c, swset, wd;
    logic [15:0]        rd_q, rd_d;
    logic               irq_out_q;
    logic [ID_W-1:0]    irq_id_q;
    logic               strobe;
    logic               unused_wd;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .d_i     (irq_in[i]),
            .q_o     (s[i])
        );
    end

    assign strobe    = chipselect && !write_n;
    assign wd        = writedata[NUM_SRC-1:0];
    assign unused_wd = ^writedata;

    assign rise    = edge_sel_q & s & ~s_d_q;
    assign w1c     = (strobe && address == ADDR_PENDING) ? wd : '0;
    assign swset   = (strobe && address == ADDR_SW_SET)  ? wd : '0;
    assign pending = (edge_sel_q & e_q) | (~edge_sel_q & s);
    assign active  = pending & mask_q;

    // Next-state for software registers and edge latches; sets beat W1C.
    always_comb begin
        mask_d     = mask_q;
        edge_sel_d = edge_sel_q;
        if (strobe && address == ADDR_MASK)     mask_d     = wd;
        if (strobe && address == ADDR_EDGE_SEL) edge_sel_d = wd;
        e_d = edge_sel_q & ((e_q & ~w1c) | rise | swset);
    end

    // Read mux; sampled every cycle from pre-write register state.
    always_comb begin
        rd_d = '0;
        case (address)
            ADDR_PENDING:  rd_d = 16'(pending);
            ADDR_MASK:     rd_d = 16'(mask_q);
            ADDR_EDGE_SEL: rd_d = 16'(edge_sel_q);
            ADDR_ACTIVE:   rd_d = {irq_out_q, 11'b0, irq_id_q};
            ADDR_RAW:      rd_d = 16'(s);
            default:       rd_d = '0;
        endcase
    end

    // All controller state, including registered CPU-facing outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_d_q      <= '0;
            mask_q     <= '0;
            edge_sel_q <= '0;
            e_q        <= '0;
            rd_q       <= '0;
            irq_out_q  <= 1'b0;
            irq_id_q   <= '0;
        end else begin
            s_d_q      <= s;
            mask_q     <= mask_d;
            edge_sel_q <= edge_sel_d;
            e_q        <= e_d;
            rd_q       <= rd_d;
            irq_out_q  <= |active;
            irq_id_q   <= lowest_set(16'(active));
        end
    end

    assign readdata = rd_q;
    assign irq_out  = irq_out_q;
    assign irq_id   = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl with a read scoreboard.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = 16'h0;
    logic [15:0] readdata;
    logic [N-1:0] irq_in = '0;
    logic        irq_out;
    logic [3:0]  irq_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;
    exp_t sb_q[$];

    irq_ctrl #(.NUM_SRC(N), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq_out    (irq_out),
        .irq_id     (irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0;
    endtask

    task automatic rd(input logic [2:0] a, input string tag, input logic [15:0] exp);
        exp_t e;
        e.tag = tag; e.exp = exp;
        sb_q.push_back(e);
        address = a;
        tick(1);
        e = sb_q.pop_front();
        chk(e.tag, 32'(readdata), 32'(e.exp));
    endtask

    task automatic irq_chk(input string tag, input logic o, input logic [3:0] id);
        chk({tag, "_out"}, 32'(irq_out), 32'(o));
        if (o) chk({tag, "_id"}, 32'(irq_id), 32'(id));
    endtask

    task automatic pulse(input int src);
        irq_in[src] = 1'b1;
        tick(1);
        irq_in[src] = 1'b0;
    endtask

    initial begin
        tick(3);
        reset_n = 1'b1;
        tick(1);

        // reset state
        chk("rst_out", 32'(irq_out), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        for (int a = 0; a < 6; a++) rd(3'(a), "rst_rd", 16'h0000);

        // level mode on source 0
        wr(ADDR_MASK, 16'h0001);
        irq_in[0] = 1'b1;
        tick(2);
        irq_chk("lvl_early", 1'b0, 4'd0);
        tick(1);
        irq_chk("lvl_rise", 1'b1, 4'd0);
        wr(ADDR_PENDING, 16'h0001);
        tick(1);
        irq_chk("lvl_w1c", 1'b1, 4'd0);
        rd(ADDR_PENDING, "lvl_pend", 16'h0001);
        rd(ADDR_RAW, "lvl_raw", 16'h0001);
        rd(ADDR_ACTIVE, "lvl_active", 16'h8000);
        irq_in[0] = 1'b0;
        tick(2);
        irq_chk("lvl_fall_early", 1'b1, 4'd0);
        tick(1);
        irq_chk("lvl_fall", 1'b0, 4'd0);

        // edge mode on sources 2 and 3
        wr(ADDR_EDGE_SEL, 16'h000C);
        wr(ADDR_MASK, 16'h000C);
        rd(ADDR_EDGE_SEL, "esel_rb", 16'h000C);
        rd(ADDR_MASK, "mask_rb", 16'h000C);
        pulse(3);
        tick(2);
        irq_chk("edge3_early", 1'b0, 4'd0);
        tick(1);
        irq_chk("edge3", 1'b1, 4'd3);
        rd(ADDR_PENDING, "edge3_pend", 16'h0008);
        tick(3);
        irq_chk("edge3_held", 1'b1, 4'd3);
        pulse(2);
        tick(3);
        irq_chk("edge2_prio", 1'b1, 4'd2);
        rd(ADDR_PENDING, "edge23_pend", 16'h000C);
        wr(ADDR_PENDING, 16'h0004);
        irq_chk("w1c2_lat", 1'b1, 4'd2);
        tick(1);
        irq_chk("w1c2", 1'b1, 4'd3);
        wr(ADDR_PENDING, 16'h0008);
        tick(1);
        irq_chk("w1c3", 1'b0, 4'd0);

        // W1C and a new rising edge on the same bit in the same cycle
        pulse(3);
        tick(4);
        rd(ADDR_PENDING, "race_pre", 16'h0008);
        irq_in[3] = 1'b1;
        tick(1);
        irq_in[3] = 1'b0;
        tick(1);
        wr(ADDR_PENDING, 16'h0008);
        rd(ADDR_PENDING, "race_keep", 16'h0008);
        wr(ADDR_PENDING, 16'h0008);
        rd(ADDR_PENDING, "race_clr", 16'h0000);

        // SW_SET while masked, then unmask
        wr(ADDR_MASK, 16'h0000);
        wr(ADDR_EDGE_SEL, 16'h0020);
        wr(ADDR_SW_SET, 16'h0021);
        rd(ADDR_PENDING, "swset_pend", 16'h0020);
        rd(ADDR_SW_SET, "swset_rd", 16'h0000);
        irq_chk("swset_masked", 1'b0, 4'd0);
        wr(ADDR_MASK, 16'h0020);
        irq_chk("unmask_lat", 1'b0, 4'd0);
        tick(1);
        irq_chk("unmask", 1'b1, 4'd5);
        rd(ADDR_ACTIVE, "unmask_active", 16'h8005);

        // asynchronous reset mid-operation
        irq_in[1] = 1'b1;
        address = ADDR_ACTIVE;
        tick(3);
        chk("pre_rst_rd", 32'(readdata), 32'h8005);
        reset_n = 1'b0;
        #1;
        chk("arst_out", 32'(irq_out), 32'd0);
        chk("arst_id", 32'(irq_id), 32'd0);
        chk("arst_rd", 32'(readdata), 32'd0);
        tick(2);
        reset_n = 1'b1;
        rd(ADDR_MASK, "post_mask", 16'h0000);
        rd(ADDR_EDGE_SEL, "post_esel", 16'h0000);
        tick(2);
        rd(ADDR_RAW, "post_raw", 16'h0002);
        rd(ADDR_PENDING, "post_lvl", 16'h0002);
        wr(ADDR_EDGE_SEL, 16'h0002);
        wr(ADDR_MASK, 16'h0002);
        tick(3);
        irq_chk("held_no_edge", 1'b0, 4'd0);
        rd(ADDR_PENDING, "held_pend", 16'h0000);
        irq_in[1] = 1'b0;
        tick(3);
        irq_in[1] = 1'b1;
        tick(3);
        irq_chk("new_edge_early", 1'b0, 4'd0);
        tick(1);
        irq_chk("new_edge", 1'b1, 4'd1);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Avalon-MM slave interrupt controller sitting directly downstream of the interval timer and other peripheral interrupt sources. It synchronises up to 16 raw request lines and latches them as either level or rising-edge events. It applies a software mask and presents one combined, registered interrupt plus a lowest-number-wins source ID to the CPU. The timer's `irq` connects to source 0 in level mode; the timer keeps it asserted until its status register is cleared.

## Interface
Parameters:
- `NUM_SRC`, 8, number of interrupt sources, 1..16
- `SYNC_STAGES`, 2, flip-flop stages on each `irq_in` bit, 2..3

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `chipselect`  in  1  Avalon slave select
- `address`  in  3  register word address
- `write_n`  in  1  active-low write strobe
- `writedata`  in  16  write data
- `readdata`  out  16  registered read data
- `irq_in`  in  NUM_SRC  raw interrupt requests, asynchronous to clk
- `irq_out`  out  1  combined interrupt to the CPU, registered
- `irq_id`  out  4  lowest-numbered active source, registered; valid only while `irq_out`=1

## Operation
- Register map (bits ≥ NUM_SRC read 0 and ignore writes):
  - 0 PENDING: R, W1C. Writing 1 clears edge-latched bits; level bits ignore the write.
  - 1 MASK: R/W, 1 = enabled.
  - 2 EDGE_SEL: R/W, 1 = rising-edge mode, 0 = level mode.
  - 3 ACTIVE: R, `{irq_out, 11'b0, irq_id}`.
  - 4 SW_SET: W. Writing 1 sets the pending bit of an edge-mode source; level-mode bits ignore the write. Reads 0.
  - 5 RAW: R, synchronised `irq_in`.
  - 6, 7: read 0, writes ignored.
- Write strobe = `chipselect && !write_n`. Reads have no strobe: `readdata` reloads every cycle from the mux selected by `address`.
- Synchroniser output: `s[i]`. Previous value: `s_d[i]`.
- Edge latch `e[i]`:
  - set when `EDGE_SEL[i] && s[i] && !s_d[i]`, or on an SW_SET write of bit i;
  - cleared on a PENDING W1C of bit i;
  - forced to 0 whenever `EDGE_SEL[i]`=0, so switching a source to level mode discards its latched edge.
- `pending[i] = EDGE_SEL[i] ? e[i] : s[i]`.
- `active = pending & MASK`.
- `irq_out` and `irq_id` are registered from `|active` and the priority encode of `active`. Bit 0 has the highest priority. When nothing is active, `irq_id` = 0.
- Simultaneous events:
  - set and W1C on the same bit in the same cycle: set wins, so no event is lost;
  - SW_SET and a hardware edge together: one pending bit.
- No state machine beyond the per-bit latches. Masking never clears pending, so unmasking a pending source raises `irq_out`.

## Timing
- Reset values:
  - `readdata`, `irq_out`, `irq_id`: 0
  - MASK, EDGE_SEL: 0, so all sources default to level mode and masked
  - all edge latches and synchroniser flip-flops: 0
- `irq_in` rise to `irq_out` rise, level mode: SYNC_STAGES+1 clk edges (3 at default).
- `irq_in` rise to `irq_out` rise, edge mode: SYNC_STAGES+2 clk edges (4 at default).
- Register write to its effect on `irq_out` (MASK, W1C, SW_SET): 2 clk edges. The register updates on edge 1 and `irq_out` on edge 2.
- Read latency: 1 cycle. `readdata` reflects the register value before any write presented in the same cycle.
- Edge detection requires `s` low for at least 1 cycle between pulses. Pulses on `irq_in` shorter than 1 clk period may be missed.
- Reset asserted mid-operation clears everything asynchronously. A request held high through reset release is seen as level immediately, and as an edge only after its next 0→1 transition.

## Structure
- Package `irq_ctrl_pkg`:
  - register address localparams `ADDR_PENDING`..`ADDR_RAW`
  - `ID_W` = 4
  - priority-encode function `lowest_set(logic [15:0]) -> [3:0]`
- Sub-module `irq_sync`: a parameterised SYNC_STAGES-deep single-bit synchroniser with async reset to 0, instantiated per source.

## Test plan
- Reset → `irq_out`=0, `irq_id`=0; reading addresses 0–5 returns 0x0000.
- Level mode, MASK=0x01, drive `irq_in[0]`=1 → `irq_out`=1 and `irq_id`=0 after 3 edges; drop `irq_in[0]` → `irq_out`=0 after 3 edges. A W1C of PENDING bit 0 while high has no effect.
- EDGE_SEL=0x0C, MASK=0x0C, 1-cycle-wide pulse (after synchronisation) on `irq_in[3]`:
  - PENDING=0x0008 and `irq_id`=3 4 edges after the `irq_in` rise;
  - pulse on `irq_in[2]` → `irq_id`=2;
  - W1C 0x0004 → `irq_id`=3;
  - W1C 0x0008 → `irq_out`=0.
- Same-cycle W1C of bit 3 and a new rising edge on source 3 → PENDING bit 3 stays 1.
- SW_SET 0x0020 with EDGE_SEL bit 5=1 and MASK=0 → PENDING=0x0020, `irq_out`=0; then MASK=0x0020 → `irq_out`=1 two edges after the MASK write.
- Pulse `reset_n` low while `irq_out`=1 and edges are latched → outputs and registers 0 immediately; after release, a held-high edge-mode source stays non-pending.
